// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and helpers for the HD44780-style text LCD controller.
package lcd_pkg;

  localparam logic [7:0] LCD_CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR     = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY_INC = 8'h06;
  localparam logic [7:0] LCD_CMD_DDRAM     = 8'h80;
  localparam logic [7:0] LCD_ROW1_BASE     = 8'h40;
  localparam logic [7:0] LCD_SPACE         = 8'h20;

  localparam int INIT_LEN = 5;

  typedef enum logic [1:0] {ST_PWRUP, ST_INIT, ST_REFRESH} lcd_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SETUP, TX_HIGH, TX_WAIT} tx_state_t;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = LCD_CMD_FUNC_8B2L;
      3'd2:       init_cmd = LCD_CMD_DISP_ON;
      3'd3:       init_cmd = LCD_CMD_CLEAR;
      default:    init_cmd = LCD_CMD_ENTRY_INC;
    endcase
  endfunction

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// One LCD bus transfer: SETUP (1 cycle), HIGH (enable strobe), WAIT (command settle time).
// A new start is accepted while idle or in the final WAIT cycle so bytes run back to back.
module lcd_byte_tx
  import lcd_pkg::*;
#(
  parameter int EN_HIGH_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long_wait,
  output logic       done,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic [7:0] lcd_data
);

  localparam int CNT_MAX = max_of(EN_HIGH_CYC, max_of(CMD_WAIT_CYC, CLR_WAIT_CYC));
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  tx_state_t        state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             long_reg, long_next;
  logic             rs_reg, rs_next;
  logic [7:0]       data_reg, data_next;
  logic [CNT_W-1:0] wait_last;
  logic             accept;

  assign wait_last = long_reg ? CNT_W'(CLR_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
  assign done      = (state_reg == TX_WAIT) && (cnt_reg == wait_last);

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    long_next  = long_reg;
    rs_next    = rs_reg;
    data_next  = data_reg;
    accept     = 1'b0;
    case (state_reg)
      TX_IDLE:  accept = start;
      TX_SETUP: begin
        state_next = TX_HIGH;
        cnt_next   = '0;
      end
      TX_HIGH: begin
        if (cnt_reg == CNT_W'(EN_HIGH_CYC - 1)) begin
          state_next = TX_WAIT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      TX_WAIT: begin
        if (done) begin
          state_next = TX_IDLE;
          accept     = start;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: state_next = TX_IDLE;
    endcase
    // bus value is latched here so it stays frozen for the whole transfer
    if (accept) begin
      state_next = TX_SETUP;
      rs_next    = rs;
      data_next  = data;
      long_next  = long_wait;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= TX_IDLE;
      cnt_reg   <= '0;
      long_reg  <= 1'b0;
      rs_reg    <= 1'b0;
      data_reg  <= 8'h00;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      long_reg  <= long_next;
      rs_reg    <= rs_next;
      data_reg  <= data_next;
    end
  end

  assign lcd_en   = (state_reg == TX_HIGH);
  assign lcd_rs   = rs_reg;
  assign lcd_data = data_reg;

endmodule

// File: rtl/lcd_text_ctrl.sv
// Character LCD controller: power-up delay, init command list, then endless refresh
// of the panel from a ROWS x COLS text buffer writable at any time.
module lcd_text_ctrl
  import lcd_pkg::*;
#(
  parameter int COLS         = 16,
  parameter int ROWS         = 2,
  parameter int POWERUP_CYC  = 750000,
  parameter int EN_HIGH_CYC  = 25,
  parameter int CMD_WAIT_CYC = 2500,
  parameter int CLR_WAIT_CYC = 100000,
  localparam int ADDR_W      = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_char,
  output logic              init_done,
  output logic              frame_tick,
  output logic [7:0]        LCD_data,
  output logic              LCD_en,
  output logic              LCD_rw,
  output logic              LCD_rs,
  output logic              LCD_blon
);

  localparam int DEPTH = ROWS * COLS;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int CNT_MAX = max_of(POWERUP_CYC,
                                  max_of(EN_HIGH_CYC, max_of(CMD_WAIT_CYC, CLR_WAIT_CYC)));
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  logic [7:0]       text_reg [DEPTH];
  logic [DEPTH-1:0] we;

  lcd_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       idx_reg, idx_next;
  logic             row_reg, row_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic             is_cmd_reg, is_cmd_next;
  logic             init_done_reg, init_done_next;

  logic             tx_start, tx_rs, tx_long, tx_done;
  logic [7:0]       tx_data;
  logic             frame_end;
  logic [COL_W-1:0] rd_col;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]       rd_char;

  // Out-of-range addresses match no entry, so they leave the buffer untouched.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
      assign we[gi] = wr_en && (wr_addr == ADDR_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (rst) begin
        text_reg[i] <= LCD_SPACE;
      end else if (we[i]) begin
        text_reg[i] <= wr_char;
      end
    end
  end

  // Character for the next data byte; read when its start is issued so a
  // same-cycle write during its SETUP lands only for the following frame.
  assign rd_col  = (is_cmd_reg || col_reg == COL_W'(COLS - 1)) ? '0 : col_reg + COL_W'(1);
  assign rd_addr = ADDR_W'(int'(row_reg) * COLS + int'(rd_col));
  assign rd_char = text_reg[rd_addr];

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    idx_next       = idx_reg;
    row_next       = row_reg;
    col_next       = col_reg;
    is_cmd_next    = is_cmd_reg;
    init_done_next = init_done_reg;
    tx_start       = 1'b0;
    tx_rs          = 1'b0;
    tx_data        = 8'h00;
    tx_long        = 1'b0;
    frame_end      = 1'b0;
    case (state_reg)
      ST_PWRUP: begin
        if (cnt_reg == CNT_W'(POWERUP_CYC - 1)) begin
          state_next = ST_INIT;
          cnt_next   = '0;
          idx_next   = 3'd0;
          tx_start   = 1'b1;
          tx_data    = init_cmd(3'd0);
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      ST_INIT: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (idx_reg == 3'(INIT_LEN - 1)) begin
            state_next     = ST_REFRESH;
            init_done_next = 1'b1;
            row_next       = 1'b0;
            col_next       = '0;
            is_cmd_next    = 1'b1;
            tx_data        = LCD_CMD_DDRAM;
          end else begin
            idx_next = idx_reg + 3'd1;
            tx_data  = init_cmd(idx_next);
            tx_long  = (tx_data == LCD_CMD_CLEAR);
          end
        end
      end
      ST_REFRESH: begin
        if (tx_done) begin
          tx_start = 1'b1;
          if (is_cmd_reg) begin
            is_cmd_next = 1'b0;
            col_next    = '0;
            tx_rs       = 1'b1;
            tx_data     = rd_char;
          end else if (col_reg == COL_W'(COLS - 1)) begin
            is_cmd_next = 1'b1;
            col_next    = '0;
            if (row_reg == 1'(ROWS - 1)) begin
              row_next  = 1'b0;
              frame_end = 1'b1;
            end else begin
              row_next = row_reg + 1'b1;
            end
            tx_data = LCD_CMD_DDRAM | (row_next ? LCD_ROW1_BASE : 8'h00);
          end else begin
            col_next = col_reg + COL_W'(1);
            tx_rs    = 1'b1;
            tx_data  = rd_char;
          end
        end
      end
      default: state_next = ST_PWRUP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_PWRUP;
      cnt_reg       <= '0;
      idx_reg       <= 3'd0;
      row_reg       <= 1'b0;
      col_reg       <= '0;
      is_cmd_reg    <= 1'b1;
      init_done_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      row_reg       <= row_next;
      col_reg       <= col_next;
      is_cmd_reg    <= is_cmd_next;
      init_done_reg <= init_done_next;
    end
  end

  lcd_byte_tx #(
    .EN_HIGH_CYC (EN_HIGH_CYC),
    .CMD_WAIT_CYC(CMD_WAIT_CYC),
    .CLR_WAIT_CYC(CLR_WAIT_CYC)
  ) u_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (tx_start),
    .rs       (tx_rs),
    .data     (tx_data),
    .long_wait(tx_long),
    .done     (tx_done),
    .lcd_en   (LCD_en),
    .lcd_rs   (LCD_rs),
    .lcd_data (LCD_data)
  );

  assign init_done  = init_done_reg;
  assign frame_tick = frame_end;
  assign LCD_rw     = 1'b0;
  assign LCD_blon   = 1'b1;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed bench for lcd_text_ctrl with shortened timing and a 2x4 panel.
module tb_lcd_text_ctrl;

  localparam int COLS = 4;
  localparam int ROWS = 2;
  localparam int PW = 20;
  localparam int EH = 2;
  localparam int CW = 4;
  localparam int LW = 10;
  localparam int NB = ROWS * (COLS + 1);

  localparam logic [79:0] FRAME_BLANK = {8'h80, 8'h20, 8'h20, 8'h20, 8'h20,
                                         8'hC0, 8'h20, 8'h20, 8'h20, 8'h20};
  localparam logic [79:0] FRAME_Q     = {8'h80, 8'h20, 8'h20, 8'h20, 8'h20,
                                         8'hC0, 8'h20, 8'h51, 8'h20, 8'h20};
  localparam logic [79:0] FRAME_ABZ   = {8'h80, 8'h41, 8'h42, 8'h20, 8'h20,
                                         8'hC0, 8'h20, 8'h20, 8'h20, 8'h5A};
  localparam logic [9:0]  RS_EXP      = 10'b0111101111;
  localparam logic [39:0] INIT_SEQ    = {8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = 3'd0;
  logic [7:0] wr_char = 8'h00;
  logic       init_done, frame_tick, LCD_en, LCD_rw, LCD_rs, LCD_blon;
  logic [7:0] LCD_data;

  int  errors = 0;
  int  checks = 0;
  int  low_run = 0;
  int  tick_cnt = 0;
  int  pin_bad = 0;
  time tick_time = 0;

  always #5 clk = ~clk;

  lcd_text_ctrl #(
    .COLS(COLS), .ROWS(ROWS), .POWERUP_CYC(PW), .EN_HIGH_CYC(EH),
    .CMD_WAIT_CYC(CW), .CLR_WAIT_CYC(LW)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .init_done(init_done), .frame_tick(frame_tick), .LCD_data(LCD_data),
    .LCD_en(LCD_en), .LCD_rw(LCD_rw), .LCD_rs(LCD_rs), .LCD_blon(LCD_blon)
  );

  always @(negedge clk) begin
    if (frame_tick === 1'b1) begin
      tick_cnt = tick_cnt + 1;
      tick_time = $time;
    end
    if (LCD_rw !== 1'b0 || LCD_blon !== 1'b1) pin_bad = pin_bad + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Capture the next enable strobe: data/rs at the strobe, strobe length, stability,
  // and how many en-low cycles preceded it.
  task automatic get_byte(output logic [7:0] d, output logic r, output int hi,
                          output int gap, output bit stable, output bit ok, output time t_rise);
    int waited;
    ok = 1'b1; stable = 1'b1; hi = 0; gap = 0; waited = 0; d = 8'h00; r = 1'b0; t_rise = 0;
    do begin
      @(negedge clk);
      wr_en = 1'b0;
      if (LCD_en !== 1'b1) begin
        low_run++;
        waited++;
      end
    end while (LCD_en !== 1'b1 && waited < 400);
    if (LCD_en !== 1'b1) begin
      ok = 1'b0;
      return;
    end
    gap = low_run; d = LCD_data; r = LCD_rs; t_rise = $time;
    while (LCD_en === 1'b1 && hi < 100) begin
      hi++;
      if (LCD_data !== d || LCD_rs !== r) stable = 1'b0;
      @(negedge clk);
    end
    low_run = 1;
  endtask

  task automatic get_frame(output logic [79:0] fd, output logic [9:0] frs,
                           output bit prot_ok, output time t_first);
    logic [7:0] d; logic r; int hi, gap; bit st, ok; time t;
    prot_ok = 1'b1; fd = '0; frs = '0; t_first = 0;
    for (int i = 0; i < NB; i++) begin
      get_byte(d, r, hi, gap, st, ok, t);
      fd[79 - 8*i -: 8] = d;
      frs[9 - i] = r;
      if (!ok || hi != EH || !st || gap != CW + 1) prot_ok = 1'b0;
      if (i == 0) t_first = t;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ({LCD_en, LCD_rs, LCD_data} !== 10'h000) begin
        errors++;
        $display("FAIL reset_bus: got en/rs/data=%b/%b/%h required 0/0/00", LCD_en, LCD_rs, LCD_data);
      end
      checks++;
      if ({init_done, frame_tick, LCD_rw, LCD_blon} !== 4'b0001) begin
        errors++;
        $display("FAIL reset_flags: got done/tick/rw/blon=%b required 0001",
                 {init_done, frame_tick, LCD_rw, LCD_blon});
      end
    end
  endtask

  task automatic test_init(input bit with_writes);
    logic [7:0] d; logic r; int hi, gap, exp_gap; bit st, ok; time t;
    logic [39:0] seq;
    int t0;
    seq = INIT_SEQ;
    t0 = tick_cnt;
    rst = 1'b0;
    low_run = 1;
    if (with_writes) begin
      wr_en = 1'b1; wr_addr = 3'd0; wr_char = 8'h41;
      @(negedge clk); low_run++;
      wr_addr = 3'd1; wr_char = 8'h42;
      @(negedge clk); low_run++;
      wr_addr = 3'd7; wr_char = 8'h5A;
      @(negedge clk); low_run++;
      wr_en = 1'b0;
    end
    for (int i = 0; i < 5; i++) begin
      get_byte(d, r, hi, gap, st, ok, t);
      exp_gap = (i == 0) ? PW + 1 : (i == 4) ? LW + 1 : CW + 1;
      checks++;
      if ({r, d} !== {1'b0, seq[39 - 8*i -: 8]}) begin
        errors++;
        $display("FAIL init_byte%0d: got rs=%b data=%h required rs=0 data=%h", i, r, d, seq[39 - 8*i -: 8]);
      end
      checks++;
      if (gap != exp_gap) begin
        errors++;
        $display("FAIL init_gap%0d: got %0d en-low cycles required %0d", i, gap, exp_gap);
      end
      checks++;
      if (!ok || hi != EH || !st) begin
        errors++;
        $display("FAIL init_strobe%0d: got ok=%0d high=%0d stable=%0d required 1/%0d/1", i, ok, hi, st, EH);
      end
    end
    checks++;
    if (init_done !== 1'b0 || tick_cnt != t0) begin
      errors++;
      $display("FAIL init_early: got init_done=%b ticks=%0d required 0/0", init_done, tick_cnt - t0);
    end
  endtask

  task automatic test_blank_frame();
    logic [79:0] fd; logic [9:0] frs; bit p; time tf;
    int t0;
    t0 = tick_cnt;
    get_frame(fd, frs, p, tf);
    checks++;
    if (init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done: got %b required 1", init_done);
    end
    checks++;
    if (fd !== FRAME_BLANK || frs !== RS_EXP) begin
      errors++;
      $display("FAIL blank_frame1: got %h rs=%b required %h rs=%b", fd, frs, FRAME_BLANK, RS_EXP);
    end
    checks++;
    if (!p || tick_cnt != t0) begin
      errors++;
      $display("FAIL blank_frame1_prot: got prot=%0d ticks=%0d required 1/0", p, tick_cnt - t0);
    end
    get_frame(fd, frs, p, tf);
    checks++;
    if (fd !== FRAME_BLANK || frs !== RS_EXP || !p) begin
      errors++;
      $display("FAIL blank_frame2: got %h rs=%b prot=%0d required %h rs=%b prot=1", fd, frs, p, FRAME_BLANK, RS_EXP);
    end
    checks++;
    if (tick_cnt != t0 + 1) begin
      errors++;
      $display("FAIL frame_tick_count: got %0d required %0d", tick_cnt - t0, 1);
    end
    checks++;
    if (tf - tick_time != 20) begin
      errors++;
      $display("FAIL frame_tick_time: got %0t before next strobe required 20", tf - tick_time);
    end
    checks++;
    if (pin_bad != 0) begin
      errors++;
      $display("FAIL rw_blon: got %0d bad cycles required 0", pin_bad);
    end
  endtask

  task automatic test_same_cycle_write();
    logic [79:0] fd; logic [9:0] frs; bit p; time tf;
    logic [7:0] d; logic r; int hi, gap; bit st, ok; time t;
    int t0;
    t0 = tick_cnt;
    p = 1'b1; fd = '0; frs = '0;
    for (int i = 0; i < NB; i++) begin
      if (i == 7) begin
        repeat (4) begin
          @(negedge clk);
          low_run++;
        end
        checks++;
        if ({LCD_en, LCD_rs, LCD_data} !== {1'b0, 1'b1, 8'h20}) begin
          errors++;
          $display("FAIL setup_addr5: got en/rs/data=%b/%b/%h required 0/1/20", LCD_en, LCD_rs, LCD_data);
        end
        wr_en = 1'b1; wr_addr = 3'd5; wr_char = 8'h51;
      end
      get_byte(d, r, hi, gap, st, ok, t);
      fd[79 - 8*i -: 8] = d;
      frs[9 - i] = r;
      if (!ok || hi != EH || !st || gap != CW + 1) p = 1'b0;
    end
    checks++;
    if (fd !== FRAME_BLANK || frs !== RS_EXP || !p) begin
      errors++;
      $display("FAIL same_cycle_old: got %h rs=%b prot=%0d required %h rs=%b prot=1", fd, frs, p, FRAME_BLANK, RS_EXP);
    end
    get_frame(fd, frs, p, tf);
    checks++;
    if (fd !== FRAME_Q || frs !== RS_EXP || !p) begin
      errors++;
      $display("FAIL same_cycle_next: got %h rs=%b prot=%0d required %h rs=%b prot=1", fd, frs, p, FRAME_Q, RS_EXP);
    end
    checks++;
    if (tick_cnt != t0 + 2) begin
      errors++;
      $display("FAIL tick_per_frame: got %0d required 2", tick_cnt - t0);
    end
  endtask

  task automatic test_reset_mid();
    logic [79:0] fd; logic [9:0] frs; bit p; time tf;
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (LCD_en !== 1'b1 && n < 50);
    checks++;
    if (LCD_en !== 1'b1) begin
      errors++;
      $display("FAIL mid_en_high: got en=%b required 1", LCD_en);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({LCD_en, LCD_rs, LCD_data} !== 10'h000) begin
      errors++;
      $display("FAIL mid_reset_bus: got en/rs/data=%b/%b/%h required 0/0/00", LCD_en, LCD_rs, LCD_data);
    end
    checks++;
    if ({init_done, frame_tick} !== 2'b00) begin
      errors++;
      $display("FAIL mid_reset_flags: got done/tick=%b%b required 00", init_done, frame_tick);
    end
    repeat (2) @(negedge clk);
    test_init(1'b1);
    get_frame(fd, frs, p, tf);
    checks++;
    if (fd !== FRAME_ABZ || frs !== RS_EXP || !p) begin
      errors++;
      $display("FAIL abz_frame: got %h rs=%b prot=%0d required %h rs=%b prot=1", fd, frs, p, FRAME_ABZ, RS_EXP);
    end
    checks++;
    if (init_done !== 1'b1 || pin_bad != 0) begin
      errors++;
      $display("FAIL after_reinit: got init_done=%b pin_bad=%0d required 1/0", init_done, pin_bad);
    end
  endtask

  initial begin
    test_reset();
    test_init(1'b0);
    test_blank_frame();
    test_same_cycle_write();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
